// File: rtl/alu_writeback.sv
// alu_writeback: registers ALU results into the register-file write port and branch redirect, serialising MUL/DIV hi words
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [DATA_W-1:0]  in_r0,
  input  logic               in_branch,
  input  logic [REG_AW-1:0]  in_dest,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_offset,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               br_taken,
  output logic [DATA_W-1:0]  br_target,
  output logic               stall
);
  localparam logic [1:0] IDLE = 2'd0, WR_1 = 2'd1, WR_LO_2 = 2'd2, WR_HI = 2'd3;
  logic [1:0] state;
  logic [DATA_W-1:0] r0_q;
  logic xfer, two, single, brf;
  assign in_ready = state != WR_LO_2;
  assign stall = ~in_ready;
  assign xfer = in_valid & in_ready;
  assign two = in_funct == FUNCT_W'(1) || in_funct == FUNCT_W'(2);
  assign single = (in_funct >> 3) == FUNCT_W'(1);
  assign brf = in_funct >= FUNCT_W'(3) && in_funct <= FUNCT_W'(5);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r0_q <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      br_taken <= 1'b0;
      br_target <= '0;
    end else begin
      rf_we <= 1'b0;
      br_taken <= 1'b0;
      if (state == WR_LO_2) begin
        rf_we <= 1'b1;
        rf_waddr <= '0;
        rf_wdata <= r0_q;
        state <= WR_HI;
      end else if (xfer) begin
        rf_we <= single | two;
        rf_waddr <= in_dest;
        rf_wdata <= in_result;
        br_taken <= brf & in_branch;
        br_target <= in_pc + in_offset;
        r0_q <= in_r0;
        state <= two ? WR_LO_2 : WR_1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
